// File: rtl/dcache_port_ctrl_if.sv
// D$ request/response bus between the port controller (master) and the data cache (slave).
// One request at a time; the master holds every request field stable until the ack cycle.
interface dcache_port_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_size,
                    input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_size,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/dcache_port_ctrl.sv
// Owns the single D$ port: drains retired stores from the SQ head and issues buffered loads,
// arbitrating by store-pressure watermark and a bounded load burst.
module dcache_port_ctrl #(
    parameter int WAYS          = 2,
    parameter int LSQSZ         = 8,
    parameter int STORE_HIGH_WM = 4,
    parameter int MAX_LD_BURST  = 3,
    parameter int LB_TAG_W      = 3,
    parameter int CNT_W         = $clog2(LSQSZ) + 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                except,
    input  logic [WAYS-1:0]     rob_store_retire,
    input  logic                sq_head_valid,
    input  logic [15:0]         sq_head_addr,
    input  logic [31:0]         sq_head_data,
    input  logic [1:0]          sq_head_size,
    output logic                sq_commit,
    input  logic                ld_req,
    input  logic [15:0]         ld_addr,
    input  logic [1:0]          ld_size,
    input  logic [LB_TAG_W-1:0] ld_tag,
    output logic                ld_gnt,
    output logic                ld_resp_valid,
    output logic [LB_TAG_W-1:0] ld_resp_tag,
    output logic [31:0]         ld_resp_data,
    dcache_port_ctrl_if.master  dmem,
    output logic [CNT_W-1:0]    pend_stores
);
    localparam int BURST_W = $clog2(MAX_LD_BURST + 1);
    localparam logic [CNT_W-1:0]   HIGH_WM   = CNT_W'(STORE_HIGH_WM);
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(LSQSZ);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_LD_BURST);

    typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;

    state_t               state, state_next;
    logic                 req_q, we_q;
    logic [15:0]          addr_q;
    logic [31:0]          wdata_q;
    logic [1:0]           size_q;
    logic [LB_TAG_W-1:0]  tag_q;
    logic [BURST_W-1:0]   burst;
    logic                 kill;
    logic                 store_ok, st_go, ld_go;
    logic [CNT_W-1:0]     retire_cnt, pend_next;

    assign dmem.mem_req   = req_q;
    assign dmem.mem_we    = we_q;
    assign dmem.mem_addr  = addr_q;
    assign dmem.mem_wdata = wdata_q;
    assign dmem.mem_size  = size_q;

    // The SQ head still shows the just-written store while sq_commit is high; block it.
    assign store_ok = (pend_stores != '0) && sq_head_valid && !sq_commit;

    always_comb begin
        retire_cnt = '0;
        for (int i = 0; i < WAYS; i++)
            retire_cnt = retire_cnt + CNT_W'(rob_store_retire[i]);
        pend_next = pend_stores + retire_cnt - CNT_W'(sq_commit);
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        st_go         = 1'b0;
        ld_go         = 1'b0;
        ld_gnt        = 1'b0;
        ld_resp_valid = 1'b0;
        ld_resp_tag   = '0;
        ld_resp_data  = '0;
        case (state)
            IDLE: begin
                if (store_ok && (pend_stores >= HIGH_WM || !ld_req || burst == BURST_MAX)) begin
                    st_go      = 1'b1;
                    state_next = WR_WAIT;
                end else if (ld_req && !except) begin
                    ld_go      = 1'b1;
                    ld_gnt     = 1'b1;
                    state_next = RD_WAIT;
                end
            end
            WR_WAIT: if (dmem.mem_ack) state_next = IDLE;
            RD_WAIT: begin
                if (dmem.mem_ack) begin
                    state_next = IDLE;
                    if (!kill && !except) begin
                        ld_resp_valid = 1'b1;
                        ld_resp_tag   = tag_q;
                        ld_resp_data  = dmem.mem_rdata;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            tag_q       <= '0;
            burst       <= '0;
            kill        <= 1'b0;
            sq_commit   <= 1'b0;
            pend_stores <= '0;
        end else begin
            sq_commit   <= (state == WR_WAIT) && dmem.mem_ack;
            pend_stores <= pend_next;
            if (st_go) begin
                req_q   <= 1'b1;
                we_q    <= 1'b1;
                addr_q  <= sq_head_addr;
                wdata_q <= sq_head_data;
                size_q  <= sq_head_size;
                burst   <= '0;
            end else if (ld_go) begin
                req_q   <= 1'b1;
                we_q    <= 1'b0;
                addr_q  <= ld_addr;
                wdata_q <= '0;
                size_q  <= ld_size;
                tag_q   <= ld_tag;
                if (store_ok) burst <= burst + 1'b1;
            end else if (state != IDLE && dmem.mem_ack) begin
                req_q <= 1'b0;
            end
            if (except) burst <= '0;
            // A flushed load still occupies the port until D$ acks; only its response dies.
            if (state == RD_WAIT) kill <= (kill || except) && !dmem.mem_ack;
            else                  kill <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (pend_next <= CNT_MAX);
            assert (!(except && pend_stores != '0));
        end
    end
endmodule

// File: tb/tb_dcache_port_ctrl.sv
// Directed bench for dcache_port_ctrl: load path, store drain, arbitration, flush and reset.
module tb_dcache_port_ctrl;
    logic        clock = 1'b0;
    logic        reset, except;
    logic [1:0]  rob_store_retire;
    logic        sq_head_valid;
    logic [15:0] sq_head_addr;
    logic [31:0] sq_head_data;
    logic [1:0]  sq_head_size;
    logic        sq_commit;
    logic        ld_req;
    logic [15:0] ld_addr;
    logic [1:0]  ld_size;
    logic [2:0]  ld_tag;
    logic        ld_gnt, ld_resp_valid;
    logic [2:0]  ld_resp_tag;
    logic [31:0] ld_resp_data;
    logic [3:0]  pend_stores;
    int          n_chk = 0;
    int          n_fail = 0;

    dcache_port_ctrl_if dmem_bus ();

    dcache_port_ctrl dut (
        .clock(clock), .reset(reset), .except(except), .rob_store_retire(rob_store_retire),
        .sq_head_valid(sq_head_valid), .sq_head_addr(sq_head_addr), .sq_head_data(sq_head_data),
        .sq_head_size(sq_head_size), .sq_commit(sq_commit), .ld_req(ld_req), .ld_addr(ld_addr),
        .ld_size(ld_size), .ld_tag(ld_tag), .ld_gnt(ld_gnt), .ld_resp_valid(ld_resp_valid),
        .ld_resp_tag(ld_resp_tag), .ld_resp_data(ld_resp_data), .dmem(dmem_bus),
        .pend_stores(pend_stores)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Retire pulses last exactly one cycle.
    task automatic cyc();
        @(posedge clock);
        #1;
        rob_store_retire = 2'b00;
    endtask

    // Called in an IDLE cycle where the load must win; returns in the cycle after the ack.
    task automatic load_cycle(input logic [2:0] tg, input logic [15:0] a, input logic [31:0] d);
        ld_req = 1'b1; ld_tag = tg; ld_addr = a; ld_size = 2'd2;
        #1 chk("ld_gnt", 32'(ld_gnt), 1);
        cyc();
        dmem_bus.mem_ack = 1'b1; dmem_bus.mem_rdata = d;
        #1;
        chk("ld_req_out", 32'(dmem_bus.mem_req), 1);
        chk("ld_we", 32'(dmem_bus.mem_we), 0);
        chk("ld_addr_out", 32'(dmem_bus.mem_addr), 32'(a));
        chk("ld_resp_valid", 32'(ld_resp_valid), 1);
        chk("ld_resp_tag", 32'(ld_resp_tag), 32'(tg));
        chk("ld_resp_data", ld_resp_data, d);
        cyc();
        dmem_bus.mem_ack = 1'b0;
    endtask

    // Called in an IDLE cycle where the store must win; returns in the sq_commit cycle.
    task automatic store_cycle(input logic [15:0] a, input logic [31:0] d);
        #1 chk("st_decide_no_gnt", 32'(ld_gnt), 0);
        cyc();
        ld_req = 1'b0;
        #1;
        chk("st_req", 32'(dmem_bus.mem_req), 1);
        chk("st_we", 32'(dmem_bus.mem_we), 1);
        chk("st_addr", 32'(dmem_bus.mem_addr), 32'(a));
        chk("st_wdata", dmem_bus.mem_wdata, d);
        chk("st_no_early_commit", 32'(sq_commit), 0);
        dmem_bus.mem_ack = 1'b1;
        cyc();
        dmem_bus.mem_ack = 1'b0;
        #1;
        chk("st_req_drop", 32'(dmem_bus.mem_req), 0);
        chk("st_commit", 32'(sq_commit), 1);
    endtask

    initial begin
        reset = 1'b1; except = 1'b0; rob_store_retire = '0;
        sq_head_valid = 1'b0; sq_head_addr = '0; sq_head_data = '0; sq_head_size = '0;
        ld_req = 1'b0; ld_addr = '0; ld_size = '0; ld_tag = '0;
        dmem_bus.mem_ack = 1'b0; dmem_bus.mem_rdata = '0;
        cyc(); cyc();
        chk("rst_req", 32'(dmem_bus.mem_req), 0);
        chk("rst_commit", 32'(sq_commit), 0);
        chk("rst_pend", 32'(pend_stores), 0);
        chk("rst_resp", 32'(ld_resp_valid), 0);
        reset = 1'b0;
        cyc();

        // Load with ack two cycles after the grant
        ld_req = 1'b1; ld_addr = 16'h0040; ld_size = 2'd2; ld_tag = 3'd5;
        #1 chk("t1_gnt", 32'(ld_gnt), 1);
        cyc();
        ld_req = 1'b0;
        #1;
        chk("t1_req", 32'(dmem_bus.mem_req), 1);
        chk("t1_we", 32'(dmem_bus.mem_we), 0);
        chk("t1_addr", 32'(dmem_bus.mem_addr), 32'h40);
        chk("t1_no_resp_yet", 32'(ld_resp_valid), 0);
        cyc();
        dmem_bus.mem_ack = 1'b1; dmem_bus.mem_rdata = 32'hDEADBEEF;
        #1;
        chk("t1_resp_valid", 32'(ld_resp_valid), 1);
        chk("t1_resp_tag", 32'(ld_resp_tag), 5);
        chk("t1_resp_data", ld_resp_data, 32'hDEADBEEF);
        cyc();
        dmem_bus.mem_ack = 1'b0;
        #1;
        chk("t1_req_drop", 32'(dmem_bus.mem_req), 0);
        chk("t1_resp_drop", 32'(ld_resp_valid), 0);

        // Two retired stores drain in order, one pop each
        rob_store_retire = 2'b11;
        sq_head_valid = 1'b1; sq_head_addr = 16'h0100; sq_head_data = 32'h11223344; sq_head_size = 2'd2;
        cyc();
        #1 chk("t2_pend2", 32'(pend_stores), 2);
        store_cycle(16'h0100, 32'h11223344);
        chk("t2_pend_during_pop", 32'(pend_stores), 2);
        cyc();
        sq_head_addr = 16'h0104; sq_head_data = 32'h55667788;
        #1;
        chk("t2_pend1", 32'(pend_stores), 1);
        chk("t2_single_pulse", 32'(sq_commit), 0);
        chk("t2_no_double_write", 32'(dmem_bus.mem_req), 0);
        store_cycle(16'h0104, 32'h55667788);
        // Retire alongside the pop: count must not move
        rob_store_retire = 2'b01;
        cyc();
        sq_head_addr = 16'h0108; sq_head_data = 32'hAABBCCDD;
        #1 chk("t5_pend_unchanged", 32'(pend_stores), 1);

        // Load burst limit with a store pending, then burst restarts after the store
        rob_store_retire = 2'b01;
        load_cycle(3'd1, 16'h0200, 32'h00000001);
        load_cycle(3'd2, 16'h0204, 32'h00000002);
        load_cycle(3'd3, 16'h0208, 32'h00000003);
        chk("t3_pend2", 32'(pend_stores), 2);
        store_cycle(16'h0108, 32'hAABBCCDD);
        cyc();
        sq_head_addr = 16'h010C; sq_head_data = 32'h01020304;
        #1 chk("t3_pend1", 32'(pend_stores), 1);
        load_cycle(3'd4, 16'h020C, 32'h00000004);
        load_cycle(3'd5, 16'h0210, 32'h00000005);
        load_cycle(3'd6, 16'h0214, 32'h00000006);
        store_cycle(16'h010C, 32'h01020304);
        cyc();
        sq_head_valid = 1'b0;
        #1 chk("t3_pend0", 32'(pend_stores), 0);

        // Watermark: stores beat loads while pend_stores >= 4
        rob_store_retire = 2'b11; cyc();
        rob_store_retire = 2'b11; cyc();
        rob_store_retire = 2'b01; cyc();
        sq_head_valid = 1'b1; sq_head_addr = 16'h0300; sq_head_data = 32'h30303030;
        ld_req = 1'b1; ld_tag = 3'd7; ld_addr = 16'h0500;
        #1 chk("t4_pend5", 32'(pend_stores), 5);
        store_cycle(16'h0300, 32'h30303030);
        cyc();
        sq_head_addr = 16'h0304; sq_head_data = 32'h31313131; ld_req = 1'b1;
        #1 chk("t4_pend4", 32'(pend_stores), 4);
        store_cycle(16'h0304, 32'h31313131);
        cyc();
        sq_head_addr = 16'h0308; sq_head_data = 32'h32323232;
        #1 chk("t4_pend3", 32'(pend_stores), 3);
        load_cycle(3'd7, 16'h0500, 32'h77777777);
        ld_req = 1'b0;

        // Reset while a store is in WR_WAIT
        #1 chk("t7_decide", 32'(ld_gnt), 0);
        cyc();
        #1 chk("t7_in_wr_wait", 32'(dmem_bus.mem_req), 1);
        reset = 1'b1;
        cyc();
        #1;
        chk("t7_req_cleared", 32'(dmem_bus.mem_req), 0);
        chk("t7_pend_cleared", 32'(pend_stores), 0);
        chk("t7_no_commit", 32'(sq_commit), 0);
        reset = 1'b0; sq_head_valid = 1'b0;
        cyc();
        #1;
        chk("t7_still_no_commit", 32'(sq_commit), 0);
        chk("t7_still_idle", 32'(dmem_bus.mem_req), 0);

        // Flush: no grant during except, and a flushed load's response is dropped
        except = 1'b1; ld_req = 1'b1; ld_tag = 3'd3; ld_addr = 16'h0400;
        #1 chk("t6_gnt_blocked", 32'(ld_gnt), 0);
        cyc();
        except = 1'b0;
        #1;
        chk("t6_no_req", 32'(dmem_bus.mem_req), 0);
        chk("t6_gnt", 32'(ld_gnt), 1);
        cyc();
        ld_req = 1'b0; except = 1'b1;
        #1 chk("t6_req", 32'(dmem_bus.mem_req), 1);
        cyc();
        except = 1'b0; dmem_bus.mem_ack = 1'b1; dmem_bus.mem_rdata = 32'h12345678;
        #1 chk("t6_resp_killed", 32'(ld_resp_valid), 0);
        cyc();
        dmem_bus.mem_ack = 1'b0;
        #1 chk("t6_idle_after_ack", 32'(dmem_bus.mem_req), 0);
        load_cycle(3'd2, 16'h0404, 32'hCAFEF00D);
        ld_req = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
